sysid_uptime_regs: RTL and testbench

Parametrised successor to the single-word system-ID peripheral. Avalon-MM slave exposing read-only system ID and build timestamp, a free-running prescaled uptime counter with a coherent 64-bit snapshot, a control/status pair, and two scratch registers. Sits on the Nios II data master bus. Software uses it for build identification, coarse time-base and bus sanity checks.

---
 rtl/sysid_pkg.sv | 15 +
 rtl/sysid_uptime_counter.sv | 34 +++
 rtl/sysid_uptime_regs.sv | 76 +++++++
 tb/tb_sysid_uptime_regs.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/sysid_pkg.sv
// sysid_pkg: register map and bit positions shared by the system-ID/uptime peripheral.
package sysid_pkg;
    localparam logic [2:0] ADDR_ID        = 3'd0;
    localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
    localparam logic [2:0] ADDR_UPTIME_LO = 3'd2;
    localparam logic [2:0] ADDR_UPTIME_HI = 3'd3;
    localparam logic [2:0] ADDR_CTRL      = 3'd4;
    localparam logic [2:0] ADDR_STATUS    = 3'd5;
    localparam logic [2:0] ADDR_SCRATCH0  = 3'd6;
    localparam logic [2:0] ADDR_SCRATCH1  = 3'd7;
    localparam int RUN_BIT        = 0;
    localparam int CLEAR_BIT      = 1;
    localparam int IRQ_EN_BIT     = 2;
    localparam int STATUS_OVF_BIT = 0;
endpackage

// File: rtl/sysid_uptime_counter.sv
// sysid_uptime_counter: prescaled free-running uptime counter with a wrap pulse.
module sysid_uptime_counter #(
    parameter int UPTIME_W = 64,
    parameter int PRESCALE = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                run,
    input  logic                clear,
    output logic [UPTIME_W-1:0] count,
    output logic                wrap_pulse
);
    logic [15:0] pre;
    logic        tick;

    assign tick       = run && pre == 16'(PRESCALE - 1);
    // a clear in the same cycle as the final tick suppresses the wrap
    assign wrap_pulse = tick && !clear && &count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre   <= '0;
            count <= '0;
        end else if (clear) begin
            pre   <= '0;
            count <= '0;
        end else if (tick) begin
            pre   <= '0;
            count <= count + UPTIME_W'(1);
        end else if (run) begin
            pre   <= pre + 16'd1;
        end
    end
endmodule

// File: rtl/sysid_uptime_regs.sv
// sysid_uptime_regs: Avalon-MM system ID, build timestamp, uptime with coherent snapshot, ctrl/status, scratch.
module sysid_uptime_regs
    import sysid_pkg::*;
#(
    parameter logic [31:0] ID_VALUE        = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP_VALUE = 32'd1537791311,
    parameter int          UPTIME_W        = 64,
    parameter int          PRESCALE        = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        readdatavalid,
    output logic        irq
);
    logic [UPTIME_W-1:0] count;
    logic [63:0]         count64;
    logic                wrap_pulse, run, irq_en, ovf, wr_ctrl, clear, ovf_w1c;
    logic [31:0]         shadow, scratch0, scratch1, rmux;

    sysid_uptime_counter #(.UPTIME_W(UPTIME_W), .PRESCALE(PRESCALE)) u_cnt (
        .clock      (clock),
        .reset_n    (reset_n),
        .run        (run),
        .clear      (clear),
        .count      (count),
        .wrap_pulse (wrap_pulse)
    );

    assign count64 = 64'(count);
    assign wr_ctrl = write && address == ADDR_CTRL;
    assign clear   = wr_ctrl && writedata[CLEAR_BIT];
    assign ovf_w1c = write && address == ADDR_STATUS && writedata[STATUS_OVF_BIT];
    assign irq     = ovf & irq_en;

    assign rmux = address == ADDR_ID        ? ID_VALUE :
                  address == ADDR_TIMESTAMP ? TIMESTAMP_VALUE :
                  address == ADDR_UPTIME_LO ? count64[31:0] :
                  address == ADDR_UPTIME_HI ? shadow :
                  address == ADDR_CTRL      ? {29'd0, irq_en, 1'b0, run} :
                  address == ADDR_STATUS    ? {31'd0, ovf} :
                  address == ADDR_SCRATCH0  ? scratch0 : scratch1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
            shadow        <= '0;
            run           <= 1'b1;
            irq_en        <= 1'b0;
            ovf           <= 1'b0;
            scratch0      <= '0;
            scratch1      <= '0;
        end else begin
            readdatavalid <= read;
            if (read)
                readdata <= rmux;
            // LO read snapshots the upper half so a following HI read is coherent
            if (read && address == ADDR_UPTIME_LO)
                shadow <= count64[63:32];
            if (wr_ctrl) begin
                run    <= writedata[RUN_BIT];
                irq_en <= writedata[IRQ_EN_BIT];
            end
            ovf <= wrap_pulse | (ovf & ~ovf_w1c);
            if (write && address == ADDR_SCRATCH0)
                scratch0 <= writedata;
            if (write && address == ADDR_SCRATCH1)
                scratch1 <= writedata;
        end
    end
endmodule

// File: tb/tb_sysid_uptime_regs.sv
// tb_sysid_uptime_regs: directed checks on a PRESCALE=4 instance and a 33-bit PRESCALE=1 instance.
module tb_sysid_uptime_regs;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [2:0]  address[2];
    logic        read[2];
    logic        write[2];
    logic [31:0] writedata[2];
    logic [31:0] readdata[2];
    logic        readdatavalid[2];
    logic        irq[2];
    int          checks = 0;
    int          failures = 0;

    always #5 clock = ~clock;

    sysid_uptime_regs #(.PRESCALE(4)) dut0 (
        .clock(clock), .reset_n(reset_n), .address(address[0]), .read(read[0]),
        .write(write[0]), .writedata(writedata[0]), .readdata(readdata[0]),
        .readdatavalid(readdatavalid[0]), .irq(irq[0])
    );

    sysid_uptime_regs #(.UPTIME_W(33), .PRESCALE(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .address(address[1]), .read(read[1]),
        .write(write[1]), .writedata(writedata[1]), .readdata(readdata[1]),
        .readdatavalid(readdatavalid[1]), .irq(irq[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input int s, input logic [2:0] a, input logic [31:0] d);
        @(negedge clock);
        address[s] = a; writedata[s] = d; write[s] = 1'b1;
        @(negedge clock);
        write[s] = 1'b0;
    endtask

    task automatic rd(input int s, input logic [2:0] a, input logic [31:0] exp, input string tag);
        @(negedge clock);
        address[s] = a; read[s] = 1'b1;
        @(negedge clock);
        read[s] = 1'b0;
        chk({tag, "_v"}, 64'(readdatavalid[s]), 64'd1);
        chk(tag, 64'(readdata[s]), 64'(exp));
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            address[i] = '0; read[i] = 1'b0; write[i] = 1'b0; writedata[i] = '0;
        end
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_rdv", 64'(readdatavalid[0]), 64'd0);
        chk("rst_rd", 64'(readdata[0]), 64'd0);
        chk("rst_irq", 64'(irq[0]), 64'd0);
        reset_n = 1'b1;

        repeat (40) @(negedge clock);
        rd(0, 3'd2, 32'd10, "lo40");
        rd(0, 3'd3, 32'd0, "hi40");
        rd(0, 3'd0, 32'h0, "id");
        rd(0, 3'd1, 32'd1537791311, "ts");
        rd(0, 3'd4, 32'h1, "ctrl_rst");
        rd(0, 3'd5, 32'h0, "status_rst");
        chk("irq_rst", 64'(irq[0]), 64'd0);

        wr(1, 3'd4, 32'h0);
        force dut1.u_cnt.count = 33'h1_FFFF_FFFE;
        @(negedge clock);
        release dut1.u_cnt.count;
        wr(1, 3'd4, 32'h5);
        rd(1, 3'd2, 32'hFFFF_FFFF, "lo_wrap");
        chk("irq_wrap", 64'(irq[1]), 64'd1);
        rd(1, 3'd3, 32'h1, "hi_wrap");
        rd(1, 3'd5, 32'h1, "ovf_set");
        wr(1, 3'd5, 32'h1);
        chk("irq_w1c", 64'(irq[1]), 64'd0);
        rd(1, 3'd5, 32'h0, "ovf_w1c");

        wr(1, 3'd4, 32'h4);
        force dut1.u_cnt.count = 33'h1_FFFF_FFFE;
        @(negedge clock);
        release dut1.u_cnt.count;
        wr(1, 3'd4, 32'h5);
        wr(1, 3'd5, 32'h1);
        chk("irq_keep", 64'(irq[1]), 64'd1);
        rd(1, 3'd5, 32'h1, "ovf_keep");
        wr(1, 3'd5, 32'h1);
        chk("irq_clr2", 64'(irq[1]), 64'd0);

        @(negedge clock);
        address[1] = 3'd4; writedata[1] = 32'h3; write[1] = 1'b1;
        @(negedge clock);
        write[1] = 1'b0; address[1] = 3'd2; read[1] = 1'b1;
        @(negedge clock);
        read[1] = 1'b0;
        chk("lo_clr", 64'(readdata[1]), 64'd0);
        rd(1, 3'd4, 32'h1, "ctrl_clr");

        wr(0, 3'd6, 32'hDEAD_BEEF);
        wr(0, 3'd7, 32'h1234_5678);
        @(negedge clock);
        address[0] = 3'd6; read[0] = 1'b1;
        @(negedge clock);
        address[0] = 3'd7;
        chk("b2b0_v", 64'(readdatavalid[0]), 64'd1);
        chk("b2b0", 64'(readdata[0]), 64'hDEAD_BEEF);
        @(negedge clock);
        read[0] = 1'b0;
        chk("b2b1_v", 64'(readdatavalid[0]), 64'd1);
        chk("b2b1", 64'(readdata[0]), 64'h1234_5678);
        @(negedge clock);
        chk("idle_v", 64'(readdatavalid[0]), 64'd0);
        chk("hold", 64'(readdata[0]), 64'h1234_5678);

        @(negedge clock);
        address[0] = 3'd6; read[0] = 1'b1; write[0] = 1'b1; writedata[0] = 32'h1111;
        @(negedge clock);
        read[0] = 1'b0; write[0] = 1'b0;
        chk("rw_old", 64'(readdata[0]), 64'hDEAD_BEEF);
        rd(0, 3'd6, 32'h1111, "rw_new");

        wr(0, 3'd0, 32'hFFFF_FFFF);
        wr(0, 3'd1, 32'h0);
        rd(0, 3'd0, 32'h0, "ro_id");
        rd(0, 3'd1, 32'd1537791311, "ro_ts");

        @(negedge clock);
        address[0] = 3'd7; read[0] = 1'b1;
        @(posedge clock);
        #1;
        read[0] = 1'b0;
        chk("mid_v", 64'(readdatavalid[0]), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_v", 64'(readdatavalid[0]), 64'd0);
        chk("mid_rst_rd", 64'(readdata[0]), 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        rd(0, 3'd6, 32'h0, "scr0_rst");
        rd(0, 3'd7, 32'h0, "scr1_rst");
        rd(0, 3'd4, 32'h1, "ctrl_rst2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
